// File: rtl/hamming_pkg.sv
// Shared SECDED (8,4) definitions for the link's transmit and receive sides.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: FSM state type for the serial transmitter, codeword bit
// positions (bit index equals Hamming position, overall parity at 0) and
// the encoder function used by both the transmitter and syndrome checker.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_estado_t;

    localparam int POS_P0 = 0;
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_D0 = 3;
    localparam int POS_P4 = 4;
    localparam int POS_D1 = 5;
    localparam int POS_D2 = 6;
    localparam int POS_D3 = 7;

    // Nibble {d3,d2,d1,d0} -> codeword with even overall parity in bit 0.
    function automatic logic [7:0] hamming_encode(input logic [3:0] d);
        logic [7:0] cw;
        cw         = '0;
        cw[POS_D0] = d[0];
        cw[POS_D1] = d[1];
        cw[POS_D2] = d[2];
        cw[POS_D3] = d[3];
        cw[POS_P1] = d[0] ^ d[1] ^ d[3];
        cw[POS_P2] = d[0] ^ d[2] ^ d[3];
        cw[POS_P4] = d[1] ^ d[2] ^ d[3];
        // Overall parity covers everything else, so it is computed last.
        cw[POS_P0] = ^cw[7:1];
        return cw;
    endfunction

endpackage

// File: rtl/codificador_hamming_8_4.sv
// Combinational Hamming SECDED (8,4) encoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   i_dato    [3:0]  data nibble {d3,d2,d1,d0}
//   o_palabra [7:0]  codeword, bit index = Hamming position, bit 0 = overall parity
module codificador_hamming_8_4
    import hamming_pkg::*;
(
    input  logic [3:0] i_dato,
    output logic [7:0] o_palabra
);

    assign o_palabra = hamming_encode(i_dato);

endmodule

// File: rtl/tx_hamming_serial.sv
// Encodes a nibble to a SECDED byte, applies an error mask and shifts it out UART-style.
// Latency: line goes low (start bit) the cycle after acceptance; a frame is 10*CLKS_PER_BIT cycles.
// Backpressure: listo_o is high only while idle; nibbles offered while busy are ignored.
//
// Ports:
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   dato_i/valido_i nibble input and its valid; accepted when valido_i && listo_o
//   listo_o         ready, high only in IDLE
//   error_mask_i    bits flipped in the codeword, sampled at acceptance
//   palabra_o       masked codeword of the last accepted transfer
//   tx_o            serial line (idle high, start 0, 8 data bits LSB-first, stop 1)
//   ocupado_o       frame in progress
//   fin_o           one-cycle pulse on the last cycle of the stop bit
module tx_hamming_serial
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dato_i,
    input  logic       valido_i,
    output logic       listo_o,
    input  logic [7:0] error_mask_i,
    output logic [7:0] palabra_o,
    output logic       tx_o,
    output logic       ocupado_o,
    output logic       fin_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

    tx_estado_t    r_estado;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_palabra;
    logic          r_tx;
    logic          r_listo;
    logic          r_ocupado;
    logic          r_fin;

    logic [7:0]    w_cw;
    logic [7:0]    w_tx_word;
    logic          w_accept;
    logic          w_baud_last;

    codificador_hamming_8_4 u_codificador (
        .i_dato    (dato_i),
        .o_palabra (w_cw)
    );

    assign w_tx_word   = w_cw ^ error_mask_i;
    assign w_accept    = valido_i && r_listo;
    assign w_baud_last = (r_baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado  <= IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_palabra <= '0;
            r_tx      <= 1'b1;
            r_listo   <= 1'b1;
            r_ocupado <= 1'b0;
            r_fin     <= 1'b0;
        end else begin
            case (r_estado)
                IDLE: begin
                    if (w_accept) begin
                        r_estado  <= START;
                        r_palabra <= w_tx_word;
                        r_shift   <= w_tx_word;
                        r_baud    <= '0;
                        r_bit     <= '0;
                        r_tx      <= 1'b0;
                        r_listo   <= 1'b0;
                        r_ocupado <= 1'b1;
                    end
                end

                START: begin
                    if (w_baud_last) begin
                        r_baud   <= '0;
                        r_estado <= DATA;
                        r_tx     <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_estado <= STOP;
                            r_tx     <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                STOP: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit     <= '0;
                        r_estado  <= IDLE;
                        r_tx      <= 1'b1;
                        r_listo   <= 1'b1;
                        r_ocupado <= 1'b0;
                        r_fin     <= 1'b0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        // Registered one cycle early so the pulse lands on the final stop cycle.
                        r_fin  <= (r_baud == BAUD_PRE);
                    end
                end

                default: begin
                    r_estado <= IDLE;
                end
            endcase
        end
    end

    assign listo_o   = r_listo;
    assign palabra_o = r_palabra;
    assign tx_o      = r_tx;
    assign ocupado_o = r_ocupado;
    assign fin_o     = r_fin;

endmodule

// File: tb/tb_tx_hamming_serial.sv
// Self-checking bench for tx_hamming_serial: scoreboard of expected codewords,
// per-cycle traces of the serial frame compared against a reference built here.
module tb_tx_hamming_serial;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dato_i;
    logic       valido_i;
    logic       listo_o;
    logic [7:0] error_mask_i;
    logic [7:0] palabra_o;
    logic       tx_o;
    logic       ocupado_o;
    logic       fin_o;

    always #5 clk = ~clk;

    tx_hamming_serial #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dato_i       (dato_i),
        .valido_i     (valido_i),
        .listo_o      (listo_o),
        .error_mask_i (error_mask_i),
        .palabra_o    (palabra_o),
        .tx_o         (tx_o),
        .ocupado_o    (ocupado_o),
        .fin_o        (fin_o)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    // Captured frame (cycle j after acceptance stored at index j-1).
    logic [FRAME-1:0] tr_tx, tr_fin, tr_ocu, tr_lis;
    logic [7:0]       rx_word, pal_first, pal_after;
    logic             lis_after, ocu_after;

    // Reference encoder written by Hamming position: parity bit p covers every
    // position whose index has bit p set.
    function automatic logic [7:0] model_encode(input logic [3:0] d);
        logic [7:0] cw;
        logic       par;
        cw    = '0;
        cw[3] = d[0];
        cw[5] = d[1];
        cw[6] = d[2];
        cw[7] = d[3];
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int i = 1; i < 8; i++)
                if (((i & p) != 0) && (i != p)) par = par ^ cw[i];
            cw[p] = par;
        end
        cw[0] = ^cw[7:1];
        return cw;
    endfunction

    function automatic logic [FRAME-1:0] model_tx_trace(input logic [7:0] w);
        logic [FRAME-1:0] t;
        for (int j = 1; j <= FRAME; j++) begin
            if (j <= CPB)          t[j-1] = 1'b0;
            else if (j <= 9 * CPB) t[j-1] = w[(j - CPB - 1) / CPB];
            else                   t[j-1] = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [FRAME-1:0] model_fin_trace();
        logic [FRAME-1:0] t;
        t = '0;
        t[FRAME-1] = 1'b1;
        return t;
    endfunction

    // Waits for the idle state, offers a nibble and returns just after the acceptance edge.
    task automatic accept(input logic [3:0] d, input logic [7:0] m, input bit keep_valid);
        int w;
        w = 0;
        @(negedge clk);
        while (listo_o !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: listo_o=%b never high within 400 cycles, required 1", listo_o);
            return;
        end
        dato_i       = d;
        error_mask_i = m;
        valido_i     = 1'b1;
        exp_q.push_back(model_encode(d) ^ m);
        @(posedge clk);
        #1;
        if (!keep_valid) valido_i = 1'b0;
    endtask

    // Captures FRAME cycles of a frame plus the following cycle (no checking here).
    task automatic recv_frame();
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk);
            tr_tx[j-1]  = tx_o;
            tr_fin[j-1] = fin_o;
            tr_ocu[j-1] = ocupado_o;
            tr_lis[j-1] = listo_o;
            if (j == 1) pal_first = palabra_o;
            if (j > CPB && j <= 9 * CPB && ((j - 1) % CPB) == CPB / 2)
                rx_word[(j - 1) / CPB - 1] = tx_o;
        end
        @(negedge clk);
        lis_after = listo_o;
        ocu_after = ocupado_o;
        pal_after = palabra_o;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        valido_i = 1'b1;   // offered during reset: must not be accepted
        dato_i   = 4'b1011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx_o !== 1'b1)        begin n_errors++; $display("FAIL reset_tx: got %b want 1", tx_o); end
        n_checks++; if (listo_o !== 1'b1)     begin n_errors++; $display("FAIL reset_listo: got %b want 1", listo_o); end
        n_checks++; if (ocupado_o !== 1'b0)   begin n_errors++; $display("FAIL reset_ocupado: got %b want 0", ocupado_o); end
        n_checks++; if (fin_o !== 1'b0)       begin n_errors++; $display("FAIL reset_fin: got %b want 0", fin_o); end
        n_checks++; if (palabra_o !== 8'h00)  begin n_errors++; $display("FAIL reset_palabra: got %h want 00", palabra_o); end
        valido_i = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        accept(4'b1011, 8'h00, 1'b0);
        recv_frame();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if (pal_first !== exp)                  begin n_errors++; $display("FAIL basic_palabra: got %h want %h", pal_first, exp); end
        n_checks++; if (pal_first !== 8'hAA)                begin n_errors++; $display("FAIL basic_palabra_const: got %h want AA", pal_first); end
        n_checks++; if (tr_tx !== model_tx_trace(exp))      begin n_errors++; $display("FAIL basic_tx_trace: got %h want %h", tr_tx, model_tx_trace(exp)); end
        n_checks++; if (tr_fin !== model_fin_trace())       begin n_errors++; $display("FAIL basic_fin_trace: got %h want %h", tr_fin, model_fin_trace()); end
        n_checks++; if (tr_ocu !== '1)                      begin n_errors++; $display("FAIL basic_ocupado_trace: got %h want all ones", tr_ocu); end
        n_checks++; if (tr_lis !== '0)                      begin n_errors++; $display("FAIL basic_listo_trace: got %h want all zeros", tr_lis); end
        n_checks++; if (lis_after !== 1'b1 || ocu_after !== 1'b0)
                                                            begin n_errors++; $display("FAIL basic_after: listo=%b ocupado=%b want 1/0", lis_after, ocu_after); end
        n_checks++; if (pal_after !== exp)                  begin n_errors++; $display("FAIL basic_palabra_hold: got %h want %h", pal_after, exp); end
    endtask

    task automatic test_patterns();
        logic [3:0] pats [3];
        logic [7:0] exp;
        pats[0] = 4'b0001;
        pats[1] = 4'b1111;
        pats[2] = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            accept(pats[i], 8'h00, 1'b0);
            recv_frame();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++; if (pal_first !== exp) begin n_errors++; $display("FAIL pattern_palabra[%0d]: got %h want %h", i, pal_first, exp); end
            n_checks++; if (rx_word !== exp)   begin n_errors++; $display("FAIL pattern_serial[%0d]: got %h want %h", i, rx_word, exp); end
            n_checks++; if (tr_tx !== model_tx_trace(exp))
                                               begin n_errors++; $display("FAIL pattern_tx_trace[%0d]: got %h want %h", i, tr_tx, model_tx_trace(exp)); end
        end
    endtask

    task automatic test_error_inject();
        logic [7:0] exp;
        logic [3:0] syn;
        accept(4'b1011, 8'h20, 1'b0);
        recv_frame();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if (pal_first !== exp)   begin n_errors++; $display("FAIL inject_palabra: got %h want %h", pal_first, exp); end
        n_checks++; if (pal_first !== 8'h8A) begin n_errors++; $display("FAIL inject_palabra_const: got %h want 8A", pal_first); end
        n_checks++; if (rx_word !== exp)     begin n_errors++; $display("FAIL inject_serial: got %h want %h", rx_word, exp); end
        syn = {1'b0,
               rx_word[4] ^ rx_word[5] ^ rx_word[6] ^ rx_word[7],
               rx_word[2] ^ rx_word[3] ^ rx_word[6] ^ rx_word[7],
               rx_word[1] ^ rx_word[3] ^ rx_word[5] ^ rx_word[7]};
        n_checks++; if (syn !== 4'b0101)     begin n_errors++; $display("FAIL inject_syndrome: got %b want 0101", syn); end
        n_checks++; if ((^rx_word) !== 1'b1) begin n_errors++; $display("FAIL inject_overall_parity: got %b want 1", ^rx_word); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        accept(4'b0011, 8'h00, 1'b1);
        // While busy: change dato_i to junk, then present the second nibble before the idle cycle.
        fork
            begin
                repeat (40) @(negedge clk);
                dato_i = 4'b0110;
                repeat (100) @(negedge clk);
                dato_i = 4'b1100;
                exp_q.push_back(model_encode(4'b1100));
            end
        join_none
        recv_frame();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if (rx_word !== exp)   begin n_errors++; $display("FAIL b2b_first_serial: got %h want %h", rx_word, exp); end
        n_checks++; if (pal_after !== exp) begin n_errors++; $display("FAIL b2b_busy_ignored: got %h want %h", pal_after, exp); end
        n_checks++; if (tr_lis !== '0 || lis_after !== 1'b1)
                                           begin n_errors++; $display("FAIL b2b_listo_first: trace=%h after=%b want zeros/1", tr_lis, lis_after); end
        fork
            begin
                @(posedge clk);
                #1;
                valido_i = 1'b0;
            end
        join_none
        recv_frame();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if (tr_lis[0] !== 1'b0) begin n_errors++; $display("FAIL b2b_listo_one_cycle: got %b want 0", tr_lis[0]); end
        n_checks++; if (tr_tx !== model_tx_trace(exp))
                                            begin n_errors++; $display("FAIL b2b_second_tx_trace: got %h want %h", tr_tx, model_tx_trace(exp)); end
        n_checks++; if (pal_first !== exp)  begin n_errors++; $display("FAIL b2b_second_palabra: got %h want %h", pal_first, exp); end
        n_checks++; if (lis_after !== 1'b1) begin n_errors++; $display("FAIL b2b_no_third: listo=%b want 1", lis_after); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp;
        int         fin_seen;
        int         bad_idle;
        fin_seen = 0;
        accept(4'b0110, 8'h00, 1'b0);
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (fin_o === 1'b1) fin_seen++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_o !== 1'b1)       begin n_errors++; $display("FAIL midrst_tx: got %b want 1", tx_o); end
        n_checks++; if (ocupado_o !== 1'b0)  begin n_errors++; $display("FAIL midrst_ocupado: got %b want 0", ocupado_o); end
        n_checks++; if (palabra_o !== 8'h00) begin n_errors++; $display("FAIL midrst_palabra: got %h want 00", palabra_o); end
        n_checks++; if (listo_o !== 1'b1)    begin n_errors++; $display("FAIL midrst_listo: got %b want 1", listo_o); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());   // abandoned frame
        rst_n    = 1'b1;
        bad_idle = 0;
        for (int j = 0; j < 2 * CPB * 10; j++) begin
            @(negedge clk);
            if (fin_o === 1'b1) fin_seen++;
            if (tx_o !== 1'b1 || ocupado_o !== 1'b0) bad_idle++;
        end
        n_checks++; if (fin_seen != 0) begin n_errors++; $display("FAIL midrst_no_fin: got %0d pulses want 0", fin_seen); end
        n_checks++; if (bad_idle != 0) begin n_errors++; $display("FAIL midrst_idle_line: got %0d non-idle cycles want 0", bad_idle); end
        accept(4'b1001, 8'h00, 1'b0);
        recv_frame();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if (tr_tx !== model_tx_trace(exp)) begin n_errors++; $display("FAIL midrst_next_tx_trace: got %h want %h", tr_tx, model_tx_trace(exp)); end
        n_checks++; if (tr_fin !== model_fin_trace())  begin n_errors++; $display("FAIL midrst_next_fin: got %h want %h", tr_fin, model_fin_trace()); end
        n_checks++; if (pal_first !== exp)             begin n_errors++; $display("FAIL midrst_next_palabra: got %h want %h", pal_first, exp); end
    endtask

    initial begin
        rst_n        = 1'b0;
        valido_i     = 1'b0;
        dato_i       = 4'b0000;
        error_mask_i = 8'h00;
        test_reset();
        test_basic();
        test_patterns();
        test_error_inject();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_hamming_serial.md
# tx_hamming_serial

Transmit side of the board's Hamming SECDED link. It accepts a 4-bit data nibble through a valid/ready handshake and encodes it into an 8-bit SECDED codeword. An optional error-injection mask is XORed into the codeword. The result is shifted out on a single UART-style serial line. It drives the codewords that the receiver's syndrome detector (4-bit syndrome from 8-bit word) checks. The latched codeword is also exposed in parallel for LEDs and debug.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be ≥2.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `dato_i` in 4: data nibble `{d3,d2,d1,d0}`.
- `valido_i` in 1: `dato_i` is valid.
- `listo_o` out 1: block can accept a nibble.
- `error_mask_i` in 8: bits to flip in the codeword. Sampled at acceptance.
- `palabra_o` out 8: codeword of the last accepted transfer, after the mask is applied.
- `tx_o` out 1: serial line. Idles high.
- `ocupado_o` out 1: frame in progress.
- `fin_o` out 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- Codeword layout, with bit index equal to Hamming position:
  - `cw[1]=p1`, `cw[2]=p2`, `cw[3]=d0`, `cw[4]=p4`, `cw[5]=d1`, `cw[6]=d2`, `cw[7]=d3`, `cw[0]=p0`.
  - `p1=d0^d1^d3`, `p2=d0^d2^d3`, `p4=d1^d2^d3`.
  - `p0` = XOR of `cw[7:1]` (even overall parity).
- Transmitted word: `tx_word = cw ^ error_mask_i`, captured on the acceptance edge.
- Handshake:
  - A transfer is accepted on a rising edge where `valido_i && listo_o`.
  - `listo_o` is 1 only in IDLE.
  - `dato_i` is ignored when `listo_o` is 0.
- State machine:
  - IDLE → START on acceptance.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → IDLE after `CLKS_PER_BIT` cycles.
- Line levels: START drives `tx_o=0`. DATA sends `tx_word[0]` first, LSB-first. STOP and IDLE drive `tx_o=1`.
- Counters:
  - Baud counter `0..CLKS_PER_BIT-1`, width `$clog2(CLKS_PER_BIT)`. It wraps to 0 on every bit boundary.
  - Bit index is 3 bits. The DATA→STOP transition happens when index 7 completes. The index never wraps inside a frame.
- `ocupado_o` is 1 in START, DATA and STOP.
- `palabra_o` updates on acceptance and holds until the next acceptance.
- `tx_o`, `listo_o`, `ocupado_o` and `fin_o` are registered outputs. There is no combinational path from any input to any output.

## Timing
- Reset values (after a `clk` edge with `rst_n=0`): `tx_o=1`, `listo_o=1`, `ocupado_o=0`, `fin_o=0`, `palabra_o=8'h00`, state IDLE, counters 0.
- Acceptance at edge T:
  - From T+1: `tx_o=0`, `listo_o=0`, `ocupado_o=1`, `palabra_o` valid.
- Data bit k occupies cycles T+1+(k+1)·`CLKS_PER_BIT` to T+(k+2)·`CLKS_PER_BIT`.
- Stop bit occupies T+1+9·`CLKS_PER_BIT` to T+10·`CLKS_PER_BIT`. `fin_o=1` only in the final cycle of that interval.
- From T+10·`CLKS_PER_BIT`+1: `listo_o=1`, `ocupado_o=0`. A frame is exactly 10·`CLKS_PER_BIT` cycles.
- Minimum spacing: one IDLE cycle between frames. The next acceptance can occur at T+10·`CLKS_PER_BIT`+1.
- `valido_i` held high continuously: a new frame is accepted every 10·`CLKS_PER_BIT`+1 cycles.
- Reset mid-frame: the frame is abandoned at the next edge. `tx_o=1` with no stop bit and no `fin_o`. All outputs take their reset values.
- `valido_i` and `rst_n=0` on the same edge: reset wins and nothing is accepted.

## Structure
- Package `hamming_pkg`:
  - State enum `tx_estado_t` {IDLE, START, DATA, STOP}.
  - Position constants `POS_P0`, `POS_P1`, `POS_P2`, `POS_D0`, `POS_P4`, `POS_D1`, `POS_D2`, `POS_D3`.
  - Function `hamming_encode(logic [3:0]) → logic [7:0]`. The receiver-side syndrome logic shares this package.
- Sub-module `codificador_hamming_8_4`: purely combinational encoder wrapping `hamming_encode`.
- FSM, counters and shift register live in the top module.

## Test plan
- Reset, then `dato_i=4'b1011`, mask 0 → `palabra_o=8'hAA`. `tx_o` sequence, one bit per 16 cycles: 0, then 0,1,0,1,0,1,0,1, then 1. `fin_o` pulses once at cycle T+160.
- `dato_i=4'b0001` → `palabra_o=8'h0F`. `dato_i=4'b1111` → `8'hFF`. `dato_i=4'b0000` → `8'h00`.
- `dato_i=4'b1011`, `error_mask_i=8'h20` → `palabra_o=8'h8A`. Serial bits match `8'h8A`. Feeding this into the detector gives syndrome 0101 with an overall parity mismatch.
- `valido_i` held high with two nibbles → frames 161 cycles apart. `listo_o` is high for exactly one cycle between them. `dato_i` changes while busy are ignored.
- `rst_n` pulled low at cycle 50 of a frame → next cycle `tx_o=1`, `ocupado_o=0`, `palabra_o=0`, no `fin_o`. A following transfer completes normally.
